// File: rtl/bar_symbol_assembler.sv
// Bar width classifier and 2-of-5 symbol packer for the bar code reader front-end.
// Define SCAN_FILTER_EN to add a 2-flop synchronizer and 3-sample majority glitch filter on scan.
module bar_symbol_assembler #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned NARROW_MAX = 5,
  parameter int unsigned QUIET_CYC  = 64,
  parameter int unsigned MAX_BAR    = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan,
  output logic [4:0] I,
  output logic       I_valid,
  output logic       I_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPACE = 2'd1;
  localparam logic [1:0] ST_BAR   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] QUIET_C  = CNT_W'(QUIET_CYC);
  localparam logic [CNT_W-1:0] NARROW_C = CNT_W'(NARROW_MAX);
  localparam logic [CNT_W-1:0] MAXBAR_C = CNT_W'(MAX_BAR);

  logic             scan_s_d, scan_s_q, scan_p_q;
  logic             rise, fall;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic [2:0]       bits_d, bits_q;
  logic [3:0]       sh_d, sh_q;
  logic [4:0]       sym_d, sym_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic             bar_bit;

`ifdef SCAN_FILTER_EN
  // sync_q[1:0] is the synchronizer; sync_q[3:1] is the majority window.
  logic [3:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[2:0], scan};
    end
  end

  always_comb begin
    scan_s_d = (sync_q[1] & sync_q[2]) | (sync_q[1] & sync_q[3]) | (sync_q[2] & sync_q[3]);
  end
`else
  always_comb begin
    scan_s_d = scan;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_s_q <= 1'b0;
      scan_p_q <= 1'b0;
    end else begin
      scan_s_q <= scan_s_d;
      scan_p_q <= scan_s_q;
    end
  end

  assign rise    = scan_s_q & ~scan_p_q;
  assign fall    = ~scan_s_q & scan_p_q;
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
  assign bar_bit = (cnt_q > NARROW_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!scan_s_q) begin
          state_d = ST_SPACE;
          cnt_d   = CNT_ONE;
          bits_d  = '0;
        end
      end
      ST_SPACE: begin
        // A rising edge wins over a coincident quiet-zone timeout.
        if (rise) begin
          state_d = ST_BAR;
          cnt_d   = CNT_ONE;
        end else if (!scan_s_q && (cnt_q < QUIET_C)) begin
          cnt_d = cnt_inc;
          if ((cnt_inc == QUIET_C) && (bits_q != 3'd0)) begin
            err_d  = 1'b1;
            bits_d = '0;
          end
        end
      end
      ST_BAR: begin
        if (fall) begin
          state_d = ST_SPACE;
          cnt_d   = CNT_ONE;
          if (bits_q == 3'd4) begin
            sym_d   = {sh_q, bar_bit};
            valid_d = 1'b1;
            err_d   = ($countones({sh_q, bar_bit}) != 2);
            bits_d  = '0;
          end else begin
            sh_d   = {sh_q[2:0], bar_bit};
            bits_d = bits_q + 3'd1;
          end
        end else if (cnt_inc == MAXBAR_C) begin
          // Sensor stuck dark: abandon the symbol and wait for light.
          err_d   = 1'b1;
          bits_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bits_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign I       = sym_q;
  assign I_valid = valid_q;
  assign I_err   = err_q;

endmodule
